// File: rtl/id_seg_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct codes, field
// positions, bubble word and immediate-extension kinds.
package id_seg_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZEXT,
    IMM_JTGT,
    IMM_NONE
  } imm_kind_e;

  function automatic logic [31:0] ext_imm(input logic [25:0] tgt, input imm_kind_e kind);
    logic [31:0] r;
    case (kind)
      IMM_SEXT: r = {{16{tgt[15]}}, tgt[15:0]};
      IMM_ZEXT: r = {16'h0000, tgt[15:0]};
      IMM_JTGT: r = {6'b000000, tgt};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_seg_reg_file.sv
// 32x32 general register file: $0 hardwired to zero, two combinational read
// ports with write-through from the single write port.
module id_seg_reg_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == '0)                       rdata_a_o = '0;
    else if (we_i && waddr_i == raddr_a_i)     rdata_a_o = wdata_i;
  end

  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == '0)                       rdata_b_o = '0;
    else if (we_i && waddr_i == raddr_b_i)     rdata_b_o = wdata_i;
  end

endmodule

// File: rtl/id_seg.sv
// Instruction-decode stage: decodes IRi, reads operands, tracks in-flight
// destinations to detect RAW hazards, and latches the operand bundle for EX.
module id_seg
  import id_seg_pkg::*;
#(
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF,
  parameter int unsigned HAZARD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] NPCi,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] IRo,
  output logic [31:0] NPCo,
  output logic [31:0] Ao,
  output logic [31:0] Bo,
  output logic [31:0] Immo
);

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, dst;
  logic        use_rs, use_rt;
  imm_kind_e   kind;
  logic [31:0] rdata_a, rdata_b;
  logic        hit, bubble;

  logic [31:0] ir_q, npc_q, a_q, b_q, imm_q;
  logic [31:0] ir_d, npc_d, a_d, b_d, imm_d;
  logic        sb0_vld_d;
  logic [HAZARD_DEPTH-1:0] sb_vld_q;
  logic [4:0]              sb_reg_q [HAZARD_DEPTH];

  assign op = IRi[OP_LSB +: 6];
  assign rs = IRi[RS_LSB +: 5];
  assign rt = IRi[RT_LSB +: 5];
  assign rd = IRi[RD_LSB +: 5];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    dst    = '0;
    kind   = IMM_SEXT;
    case (op)
      OP_RTYPE:       begin use_rs = 1'b1; use_rt = 1'b1; dst = rd; kind = IMM_NONE; end
      OP_ADDI, OP_LW: begin use_rs = 1'b1; dst = rt; end
      OP_ANDI, OP_ORI: begin use_rs = 1'b1; dst = rt; kind = IMM_ZEXT; end
      OP_SW:          begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ:         use_rs = 1'b1;
      OP_J:           kind = IMM_JTGT;
      default:        kind = IMM_SEXT;
    endcase
  end

  id_seg_reg_file u_rf (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  // WB is not tracked: write-through covers a producer that is in WB now.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < HAZARD_DEPTH; i++) begin
      if (sb_vld_q[i] && ((use_rs && rs != '0 && sb_reg_q[i] == rs) ||
                          (use_rt && rt != '0 && sb_reg_q[i] == rt)))
        hit = 1'b1;
    end
  end

  assign stall  = !rst && !flush && hit;
  assign bubble = flush || hit;

  always_comb begin
    ir_d      = IRi;
    npc_d     = NPCi;
    a_d       = rdata_a;
    b_d       = rdata_b;
    imm_d     = ext_imm(IRi[25:0], kind);
    sb0_vld_d = (dst != '0);
    if (bubble) begin
      ir_d      = NOP_WORD;
      npc_d     = '0;
      a_d       = '0;
      b_d       = '0;
      imm_d     = '0;
      sb0_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= NOP_WORD;
      npc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      sb_vld_q <= '0;
      for (int unsigned i = 0; i < HAZARD_DEPTH; i++) sb_reg_q[i] <= '0;
    end else begin
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      sb_vld_q[0] <= sb0_vld_d;
      sb_reg_q[0] <= dst;
      for (int unsigned i = 1; i < HAZARD_DEPTH; i++) begin
        sb_vld_q[i] <= sb_vld_q[i-1];
        sb_reg_q[i] <= sb_reg_q[i-1];
      end
    end
  end

  assign IRo  = ir_q;
  assign NPCo = npc_q;
  assign Ao   = a_q;
  assign Bo   = b_q;
  assign Immo = imm_q;

endmodule

// File: tb/tb_id_seg.sv
// Directed bench for id_seg: reset, operand read, write-through, RAW stall,
// immediate extension, flush, $0 handling and reset during a stall.
module tb_id_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IRi, NPCi, wdata;
  logic        we, flush;
  logic [4:0]  waddr;
  logic        stall;
  logic [31:0] IRo, NPCo, Ao, Bo, Immo;

  int unsigned total = 0;
  int unsigned bad   = 0;

  id_seg #(.NOP_WORD(32'h0000_0000), .HAZARD_DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .IRi   (IRi),
    .NPCi  (NPCi),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .flush (flush),
    .stall (stall),
    .IRo   (IRo),
    .NPCo  (NPCo),
    .Ao    (Ao),
    .Bo    (Bo),
    .Immo  (Immo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; IRi = '0; NPCi = '0; we = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
    tick();
    settle();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_IRo", IRo, 32'h0);
    check("rst_NPCo", NPCo, 32'h0);
    check("rst_Ao", Ao, 32'h0);
    check("rst_Bo", Bo, 32'h0);
    check("rst_Immo", Immo, 32'h0);
    rst = 1'b0;

    // add $7,$5,$6 after reset: operands zero
    IRi = 32'h00A6_3820; NPCi = 32'h4;
    settle();
    check("r_stall", 32'(stall), 32'd0);
    tick();
    check("r_IRo", IRo, 32'h00A6_3820);
    check("r_NPCo", NPCo, 32'h4);
    check("r_Ao", Ao, 32'h0);
    check("r_Bo", Bo, 32'h0);

    // WB $3 = 0x1234 alongside a NOP
    IRi = 32'h0; NPCi = 32'h8; we = 1'b1; waddr = 5'd3; wdata = 32'h1234;
    tick();
    we = 1'b0;

    IRi = 32'h2064_FFFF; NPCi = 32'hC;
    settle();
    check("addi_stall", 32'(stall), 32'd0);
    tick();
    check("addi_Ao", Ao, 32'h0000_1234);
    check("addi_Immo", Immo, 32'hFFFF_FFFF);

    // same-cycle write-through of $3
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE; NPCi = 32'h10;
    settle();
    check("wt_stall", 32'(stall), 32'd0);
    tick();
    we = 1'b0;
    check("wt_Ao", Ao, 32'h0000_CAFE);

    // RAW: add $1,$2,$3 then sub $5,$1,$6
    IRi = 32'h0043_0820; NPCi = 32'h14;
    tick();
    check("add_Bo", Bo, 32'h0000_CAFE);
    IRi = 32'h0026_2822; NPCi = 32'h18;
    settle();
    check("raw_stall1", 32'(stall), 32'd1);
    tick();
    check("raw_bub1_IR", IRo, 32'h0);
    check("raw_bub1_NPC", NPCo, 32'h0);
    check("raw_stall2", 32'(stall), 32'd1);
    tick();
    check("raw_bub2_IR", IRo, 32'h0);
    we = 1'b1; waddr = 5'd1; wdata = 32'h55;
    settle();
    check("raw_stall3", 32'(stall), 32'd0);
    tick();
    we = 1'b0;
    check("raw_IRo", IRo, 32'h0026_2822);
    check("raw_Ao", Ao, 32'h0000_0055);

    // immediate extension
    IRi = 32'h3042_FFFF; NPCi = 32'h1C;
    tick();
    check("andi_Immo", Immo, 32'h0000_FFFF);
    IRi = 32'h0800_0010; NPCi = 32'h20;
    settle();
    check("j_stall", 32'(stall), 32'd0);
    tick();
    check("j_Immo", Immo, 32'h0000_0010);
    IRi = 32'h2128_0001; NPCi = 32'h24;
    settle();
    check("postj_stall", 32'(stall), 32'd0);
    tick();
    check("postj_Immo", Immo, 32'h0000_0001);

    // flush while a hazard is pending
    IRi = 32'h0043_0820; NPCi = 32'h28;
    tick();
    IRi = 32'h0026_2822; NPCi = 32'h2C;
    settle();
    check("fl_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    settle();
    check("fl_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    check("fl_IRo", IRo, 32'h0);
    check("fl_NPCo", NPCo, 32'h0);
    settle();
    check("fl_e1_stall", 32'(stall), 32'd1);
    tick();
    check("fl_e0_inv", 32'(stall), 32'd0);
    tick();
    check("fl_sub_Ao", Ao, 32'h0000_0055);

    // writes to $0 are dropped, including the bypass
    IRi = 32'h2004_0001; NPCi = 32'h30; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
    tick();
    we = 1'b0;
    check("r0_wt_Ao", Ao, 32'h0);
    tick();
    check("r0_Ao", Ao, 32'h0);

    // unknown opcode never stalls, sign-extended immediate
    IRi = 32'h0043_0820; NPCi = 32'h34;
    tick();
    IRi = 32'hFC21_8000; NPCi = 32'h38;
    settle();
    check("unk_stall", 32'(stall), 32'd0);
    tick();
    check("unk_IRo", IRo, 32'hFC21_8000);
    check("unk_Immo", Immo, 32'hFFFF_8000);

    // reset in the middle of a stall
    IRi = 32'h0043_0820; NPCi = 32'h3C;
    tick();
    IRi = 32'h0026_2822; NPCi = 32'h40;
    settle();
    check("rs_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    settle();
    check("rs_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    check("rs_IRo", IRo, 32'h0);
    settle();
    check("rs_post_stall", 32'(stall), 32'd0);
    tick();
    check("rs_sub_IRo", IRo, 32'h0026_2822);
    check("rs_sub_Ao", Ao, 32'h0);
    check("rs_sub_NPCo", NPCo, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_seg.md
# id_seg

Instruction-decode pipeline stage that produces the operand bundle consumed by the execute stage: latched IR, NPC, register operands A/B and the extended immediate. Contains the 32×32 general register file, with its write port driven by write-back. Contains a RAW-hazard scoreboard that stalls fetch and injects bubbles. Sits between the fetch latch and the execute stage.

## Interface
- NOP_WORD, 32'h0000_0000, instruction word issued as a bubble
- HAZARD_DEPTH, 2, number of downstream in-flight stages tracked (EX, MEM); WB is covered by write-through
- clk  in  1  stage clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- IRi  in  32  instruction from fetch latch
- NPCi  in  32  PC+4 of IRi
- we  in  1  write-back register write enable
- waddr  in  5  write-back destination register
- wdata  in  32  write-back data
- flush  in  1  kill the instruction currently in decode (taken branch/jump)
- stall  out  1  combinational; fetch must hold PC and IRi/NPCi while high
- IRo  out  32  issued instruction
- NPCo  out  32  issued NPC
- Ao  out  32  GPR[rs]
- Bo  out  32  GPR[rt]
- Immo  out  32  extended immediate

## Operation
- Fields: rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=IR[15:0], op=IR[31:26], target=IR[25:0].
- Supported ops: R-type (op 000000), addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100 (rs-only, EX tests A==0), j 000010.
- Immo: sign-extend imm for addi/lw/sw/beq and unknown ops; zero-extend for andi/ori; {6'b0,target} for j; 0 for R-type.
- Destination: rd for R-type; rt for addi/andi/ori/lw; none for sw/beq/j/unknown. Destination $0 counts as none.
- Sources: rs for R, addi, andi, ori, lw, sw, beq; rt for R and sw only.
- Register file: $0 reads 0, writes to $0 ignored. Reads are combinational. A write with we=1 and a matching nonzero waddr bypasses wdata to the read in the same cycle (write-through).
- Scoreboard: HAZARD_DEPTH entries of {valid, reg}. Each posedge: entry0 <= destination of the issued instruction (invalid for a bubble or for no destination), and the other entries shift down.
- stall = !flush && (any valid entry whose reg equals a used nonzero source).
- Issue (posedge, no stall, no flush): IRo/NPCo <= IRi/NPCi, Ao/Bo <= read values, Immo <= extended immediate.
- Bubble (stall or flush): IRo <= NOP_WORD, NPCo/Ao/Bo/Immo <= 0, entry0 invalid.
- flush has priority over stall.
- Unknown opcode: passed through with no sources and no destination; never stalls.

## Timing
- Latency: one cycle from IRi to IRo at posedge. EX samples on the following negedge, giving half a cycle of settling.
- Reset (rst high at posedge): IRo=NOP_WORD, all other outputs 0, all 32 registers 0, all scoreboard entries invalid. stall reads 0 while reset is applied.
- Back-to-back dependent ALU ops with HAZARD_DEPTH=2: stall high for exactly 2 cycles, 2 bubbles, then issue with the written value via write-through.
- Reset mid-stall: the instruction held in decode is not issued; fetch restarts.
- A write-back and a read of the same register in the same cycle return wdata. The write and issue land on the same edge.

## Structure
- Shared package: opcode and funct constants, field-slice positions, NOP_WORD default, immediate-kind enum (SEXT, ZEXT, JTGT, NONE).
- One sub-module, reg_file: 32×32 array with synchronous reset, two combinational read ports with write-through, one write port. Decode, immediate extension, scoreboard and output latch live in id_seg.

## Test plan
- Reset: assert rst one cycle -> IRo=0, Ao=Bo=Immo=NPCo=0, stall=0; then issue 0x00A63820 -> Ao=Bo=0.
- Write $3=0x1234 via WB; then IRi=0x2064FFFF (addi $4,$3,-1) -> Ao=0x00001234, Immo=0xFFFFFFFF, stall=0.
- Write-through: we=1, waddr=3, wdata=0xCAFE in the same cycle as IRi=0x2064FFFF -> Ao=0x0000CAFE.
- RAW: IRi=0x00430820 (add $1,$2,$3) then 0x00262822 (sub $5,$1,$6) -> stall high 2 cycles, 2 NOP issues. Drive WB we=1, waddr=1, wdata=0x55 on the third cycle -> sub issues with Ao=0x55.
- Extension: 0x3042FFFF (andi) -> Immo=0x0000FFFF; 0x08000010 (j) -> Immo=0x00000010, no stall on the following instruction.
- Flush during stall: flush=1 while stall would be 1 -> stall=0, bubble issued, entry0 invalid. Separately, WB write to $0 with 0xFFFF, then read rs=0 -> Ao=0.
